serial_layer_sequencer: RTL and testbench
=========================================

Name: serial_layer_sequencer

Overview:
- Sequences one shared serial neuron core over a layer of M neurons.
- Holds N input words and M×N weight words. Streams each neuron's operands into the core LSB-first, pulses the core start, waits for core rdy, and returns each result with its neuron index.
- Sits between the host/config bus and the serial neuron core. It is the only driver of the core's start, inp and w pins.

Parameters:
- N, 2, inputs per neuron (core inp/w bus width)
- WIDTH, 8, bits per input/weight word (serial stream length)
- M, 4, neurons in the layer, executed sequentially
- OUT_W, 8, core result width (2*WIDTH − skip_size, with skip_size = WIDTH)
- TIMEOUT, 64, max cycles waited for core rdy per neuron
- AW, clog2(M*N), weight address width (localparam)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  config write strobe
- wr_sel  in  1  0 = input word, 1 = weight word
- wr_addr  in  AW  input index (0..N−1) or weight index neuron*N + input
- wr_data  in  WIDTH  word to store
- run  in  1  single-cycle pulse: start layer evaluation
- busy  out  1  high from the cycle after an accepted run until done
- done  out  1  one-cycle pulse, layer finished or aborted
- err  out  1  sticky timeout flag, cleared by the next accepted run
- res_valid  out  1  one-cycle pulse per neuron result
- res_idx  out  clog2(M)  neuron index of res_data
- res_data  out  OUT_W  captured core result
- core_start  out  1  start pulse to core
- core_inp  out  N  serial input bits, bit i = input i
- core_w  out  N  serial weight bits, bit i = weight i of current neuron
- core_out  in  OUT_W  core result
- core_rdy  in  1  core result valid pulse

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Input and weight storage are not reset.
- Config writes:
  - Accepted only in IDLE.
  - Ignored while busy.
  - Out-of-range wr_addr is ignored.
- FSM states:
  - IDLE: run=1 → LOAD; clear err; neuron counter k=0. run is ignored outside IDLE.
  - LOAD (1 cycle): copy the N input words and neuron k's N weight words into per-lane shift registers → STREAM.
  - STREAM (WIDTH cycles):
    - First cycle: core_start=1, core_inp/core_w carry bit 0 (LSB) of each word.
    - Bits shift right each cycle until bit WIDTH−1.
    - Afterwards → WAIT, with core_inp/core_w driven 0.
  - WAIT:
    - Count cycles from 0.
    - core_rdy=1: register core_out into res_data, res_idx=k, res_valid=1 next cycle. If k==M−1 → DONE, else k++ and → LOAD.
    - Counter reaches TIMEOUT without rdy: err=1 → DONE, with no res_valid for neuron k.
  - DONE (1 cycle): done=1, busy=0 next cycle → IDLE.
- Latency:
  - run at edge t → core_start high in cycle t+2.
  - core_rdy at edge r → res_valid high in cycle r+1.
  - Next neuron's core_start at r+2.
- core_rdy outside WAIT is ignored (spurious; no result, no state change).
- core_rdy in the same cycle the timeout expires: rdy wins, no err.
- core_start is never high outside the first STREAM cycle.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no done pulse.
- k wraps never; the layer ends at M−1.

Decomposition:
- Shared package (nn_pkg):
  - FSM state encoding (IDLE, LOAD, STREAM, WAIT, DONE)
  - clog2 function
  - WR_SEL_INPUT / WR_SEL_WEIGHT constants
- Sub-module serial_operand_shifter: one per lane, generate loop over N. Behaviour:
  - Parallel load of a WIDTH word.
  - LSB-first shift-out with a zero fill.
  - Instantiated twice per lane: input and weight.

Test Plan:
- Stream order: N=2, WIDTH=8, in0=0x05, in1=0x03, neuron0 weights 0x01/0x02, run → core_inp sequence 11,10,01,00×5; core_w 01,10,00×6; core_start high only with the first pair.
- Full layer: core model returns rdy 20 cycles after start with core_out=0x10+k → four res_valid pulses, idx 0..3, data 0x10..0x13; then done=1, busy=0, err=0.
- Timeout: core model never asserts rdy for neuron 2 → results 0,1 only; after 64 WAIT cycles err=1, done pulse; next run clears err.
- Rdy at timeout edge: rdy on WAIT cycle 64 → result accepted, err stays 0.
- Busy protection: wr_en with weight 0xFF during STREAM and a second run pulse mid-layer → streamed bits unchanged; single done; stored weight unchanged after the layer.
- Async reset during STREAM of neuron 1 → next cycle busy=0, core_start=0, core_inp/core_w=0, no done; a fresh run completes normally.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, config-select codes and width helper for the layer sequencer.
package nn_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, WAIT, DONE} state_t;
  localparam logic WR_SEL_INPUT = 1'b0;
  localparam logic WR_SEL_WEIGHT = 1'b1;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter: parallel-load word, shifted out LSB-first with zero fill.
module serial_operand_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             lsb
);
  logic [WIDTH-1:0] sr;
  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else if (load) sr <= data;
    else if (shift) sr <= sr >> 1;
  assign lsb = sr[0];
endmodule

// File: rtl/serial_layer_sequencer.sv
// serial_layer_sequencer: drives one shared serial neuron core across the M neurons of a layer,
// streaming operands LSB-first and collecting each result with its neuron index.
module serial_layer_sequencer
  import nn_pkg::*;
#(
  parameter  int N       = 2,
  parameter  int WIDTH   = 8,
  parameter  int M       = 4,
  parameter  int OUT_W   = 8,
  parameter  int TIMEOUT = 64,
  localparam int AW      = clog2(M * N),
  localparam int KW      = clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_sel,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             run,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             res_valid,
  output logic [KW-1:0]    res_idx,
  output logic [OUT_W-1:0] res_data,
  output logic             core_start,
  output logic [N-1:0]     core_inp,
  output logic [N-1:0]     core_w,
  input  logic [OUT_W-1:0] core_out,
  input  logic             core_rdy
);
  localparam int CW = clog2(WIDTH + TIMEOUT + 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic [N-1:0] in_bits, w_bits;
  logic wr_ok, last_k, timed_out, accept;
  assign wr_ok = wr_en && state == IDLE;
  assign last_k = k == KW'(M - 1);
  assign timed_out = cnt == CW'(TIMEOUT);
  assign accept = state == WAIT && core_rdy;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? LOAD : IDLE;
      LOAD:    nxt = STREAM;
      STREAM:  nxt = (cnt == CW'(WIDTH - 1)) ? WAIT : STREAM;
      WAIT:    nxt = core_rdy ? (last_k ? DONE : LOAD) : (timed_out ? DONE : WAIT);
      default: nxt = IDLE;
    endcase
  end
  // cnt is shared: bit position in STREAM, elapsed cycles in WAIT; it restarts on every state change
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      k <= '0;
      err <= 1'b0;
      res_valid <= 1'b0;
      res_idx <= '0;
      res_data <= '0;
    end else begin
      cnt <= (state == IDLE || nxt != state) ? '0 : cnt + 1'b1;
      k <= (state == IDLE) ? '0 : (accept && !last_k) ? k + 1'b1 : k;
      res_valid <= accept;
      if (accept) begin
        res_idx <= k;
        res_data <= core_out;
      end
      if (state == IDLE && run) err <= 1'b0;
      else if (state == WAIT && !core_rdy && timed_out) err <= 1'b1;
    end
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] inp_word;
    logic [WIDTH-1:0] w_word [M];
    always_ff @(posedge clk)
      if (wr_ok && wr_sel == WR_SEL_INPUT && wr_addr == AW'(i)) inp_word <= wr_data;
    for (genvar j = 0; j < M; j++) begin : g_w
      always_ff @(posedge clk)
        if (wr_ok && wr_sel == WR_SEL_WEIGHT && wr_addr == AW'(j * N + i)) w_word[j] <= wr_data;
    end
    serial_operand_shifter #(.WIDTH(WIDTH)) u_inp (
      .clk(clk), .rst(rst), .load(state == LOAD), .shift(state == STREAM),
      .data(inp_word), .lsb(in_bits[i])
    );
    serial_operand_shifter #(.WIDTH(WIDTH)) u_w (
      .clk(clk), .rst(rst), .load(state == LOAD), .shift(state == STREAM),
      .data(w_word[k]), .lsb(w_bits[i])
    );
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign core_start = state == STREAM && cnt == '0;
  assign core_inp = (state == STREAM) ? in_bits : '0;
  assign core_w = (state == STREAM) ? w_bits : '0;
endmodule

// File: tb/tb_serial_layer_sequencer.sv
// tb_serial_layer_sequencer: directed stimulus with a result scoreboard and a behavioural core model.
module tb_serial_layer_sequencer;
  import nn_pkg::*;
  localparam int N = 2, WIDTH = 8, M = 4, OUT_W = 8, TIMEOUT = 64, AW = 3, KW = 2;
  logic clk = 0, rst = 0, wr_en = 0, wr_sel = 0, run = 0, core_rdy = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [OUT_W-1:0] core_out = '0;
  logic busy, done, err, res_valid, core_start;
  logic [KW-1:0] res_idx;
  logic [OUT_W-1:0] res_data;
  logic [N-1:0] core_inp, core_w;
  int vectors = 0, miscompares = 0, cyc = 0, done_cnt = 0;
  int start_cyc = 0, nidx = 0, mn = 0, mc = 0, rdy_delay = 20, skip = -1;
  logic pbusy = 0;
  logic [KW+OUT_W-1:0] expq [$];

  serial_layer_sequencer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .busy(busy), .done(done), .err(err), .res_valid(res_valid), .res_idx(res_idx),
    .res_data(res_data), .core_start(core_start), .core_inp(core_inp), .core_w(core_w),
    .core_out(core_out), .core_rdy(core_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scoreboard monitor: every result the DUT presents must match the head of the queue
  initial forever begin
    @(negedge clk);
    if (res_valid) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL result: got idx %0d data %h, required no result", res_idx, res_data);
      end else chk("result", {res_idx, res_data}, expq.pop_front());
    end
    if (done) done_cnt++;
  end

  // core model: answers each start after rdy_delay cycles with 0x10 + neuron number
  initial forever begin
    @(negedge clk);
    if (busy && !pbusy) nidx = 0;
    pbusy = busy;
    if (core_start) begin
      mn = nidx;
      nidx++;
      start_cyc = cyc;
      for (mc = 0; mc < rdy_delay && !rst; mc++) @(negedge clk);
      if (!rst && mn != skip) begin
        core_rdy = 1;
        core_out = OUT_W'(8'h10 + mn);
        @(negedge clk);
        core_rdy = 0;
        chk("rdy_to_valid", {res_valid, res_idx}, {1'b1, KW'(mn)});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cfg_write(input logic sel, input int addr, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1;
    wr_sel = sel;
    wr_addr = AW'(addr);
    wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic pulse_run();
    @(negedge clk);
    run = 1;
    @(negedge clk);
    run = 0;
  endtask

  task automatic push_res(input int first, input int last);
    for (int j = first; j <= last; j++) expq.push_back({KW'(j), OUT_W'(8'h10 + j)});
  endtask

  // expects inputs 0x05/0x03 with the given weight pair on the next start
  task automatic stream_check(input logic [7:0] w0, input logic [7:0] w1, output int waited);
    logic [7:0] a0, a1, c0, c1;
    waited = 0;
    while (!core_start && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!core_start) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_start: got no core_start in 100 cycles, required one");
      return;
    end
    for (int b = 0; b < WIDTH; b++) begin
      a0 = 8'h05 >> b;
      a1 = 8'h03 >> b;
      c0 = w0 >> b;
      c1 = w1 >> b;
      chk("stream_bits", {core_start, core_inp, core_w}, {b == 0, a1[0], a0[0], c1[0], c0[0]});
      @(negedge clk);
    end
    chk("stream_tail", {core_start, core_inp, core_w}, 5'b0);
  endtask

  task automatic wait_done(output int at);
    int w = 0;
    while (!done && w < 1000) begin
      @(negedge clk);
      w++;
    end
    at = cyc;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in 1000 cycles, required one");
    end
    @(negedge clk);
    chk("done_pulse", {done, busy}, 2'b00);
  endtask

  initial begin
    int at, w, t0, seen;
    #1 rst = 1;
    @(negedge clk);
    chk("reset_ctrl", {busy, done, err, res_valid, core_start}, 0);
    chk("reset_lanes", {core_inp, core_w}, 0);
    chk("reset_res", {res_idx, res_data}, 0);
    @(negedge clk);
    rst = 0;
    cfg_write(WR_SEL_INPUT, 0, 8'h05);
    cfg_write(WR_SEL_INPUT, 1, 8'h03);
    cfg_write(WR_SEL_INPUT, 3, 8'hAA);
    cfg_write(WR_SEL_WEIGHT, 0, 8'h01);
    cfg_write(WR_SEL_WEIGHT, 1, 8'h02);
    cfg_write(WR_SEL_WEIGHT, 2, 8'h04);
    cfg_write(WR_SEL_WEIGHT, 3, 8'h08);
    cfg_write(WR_SEL_WEIGHT, 4, 8'h10);
    cfg_write(WR_SEL_WEIGHT, 5, 8'h20);
    cfg_write(WR_SEL_WEIGHT, 6, 8'h40);
    cfg_write(WR_SEL_WEIGHT, 7, 8'h80);

    // full layer with a well-behaved core
    rdy_delay = 20;
    push_res(0, 3);
    t0 = done_cnt;
    pulse_run();
    chk("load_cycle", {busy, core_start}, 2'b10);
    stream_check(8'h01, 8'h02, w);
    chk("start_latency", w, 1);
    stream_check(8'h04, 8'h08, w);
    wait_done(at);
    chk("layer_err", err, 0);
    chk("layer_done_count", done_cnt - t0, 1);
    chk("layer_drained", expq.size(), 0);

    // neuron 2 never answers
    skip = 2;
    push_res(0, 1);
    pulse_run();
    wait_done(at);
    chk("timeout_err", err, 1);
    chk("timeout_cycles", at - start_cyc, 73);
    chk("timeout_drained", expq.size(), 0);

    // every answer arrives on the last permitted WAIT cycle
    skip = -1;
    rdy_delay = 8 + TIMEOUT;
    push_res(0, 3);
    pulse_run();
    chk("run_clears_err", err, 0);
    wait_done(at);
    chk("edge_err", err, 0);
    chk("edge_drained", expq.size(), 0);

    // writes and run while busy must be ignored
    rdy_delay = 20;
    push_res(0, 3);
    t0 = done_cnt;
    pulse_run();
    fork
      stream_check(8'h01, 8'h02, w);
      begin
        repeat (2) @(negedge clk);
        wr_en = 1;
        wr_sel = WR_SEL_WEIGHT;
        wr_addr = AW'(2);
        wr_data = 8'hFF;
        run = 1;
        @(negedge clk);
        wr_en = 0;
        run = 0;
      end
    join
    stream_check(8'h04, 8'h08, w);
    wait_done(at);
    repeat (5) @(negedge clk);
    chk("busy_single_done", done_cnt - t0, 1);
    chk("busy_drained", expq.size(), 0);
    push_res(0, 3);
    pulse_run();
    stream_check(8'h01, 8'h02, w);
    stream_check(8'h04, 8'h08, w);
    wait_done(at);
    chk("busy_rerun_drained", expq.size(), 0);

    // asynchronous reset while neuron 1 streams
    push_res(0, 0);
    t0 = done_cnt;
    pulse_run();
    seen = 0;
    w = 0;
    while (seen < 2 && w < 200) begin
      @(negedge clk);
      w++;
      if (core_start) seen++;
    end
    chk("reset_reached_n1", seen, 2);
    @(posedge clk);
    #2 rst = 1;
    #1 chk("reset_abort", {busy, done, res_valid, core_start, core_inp, core_w}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (10) @(negedge clk);
    chk("reset_no_done", done_cnt - t0, 0);
    chk("reset_idle", {busy, err}, 2'b00);
    chk("reset_drained", expq.size(), 0);
    push_res(0, 3);
    pulse_run();
    wait_done(at);
    chk("fresh_err", err, 0);
    chk("fresh_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
